// File: rtl/taxi_pkg.sv
// Shared types and constants for the taxi fare settlement path.
// Contents: fare width, source codes for seats and VIP, and the packed
// settlement record layout {source, fare}.
package taxi_pkg;

    localparam int unsigned FARE_W = 14;
    localparam int unsigned SRC_W  = 3;
    localparam int unsigned N_SEAT = 4;
    localparam int unsigned N_SRC  = N_SEAT + 1;

    localparam logic [SRC_W-1:0] SRC_SEAT0 = 3'd0;
    localparam logic [SRC_W-1:0] SRC_SEAT1 = 3'd1;
    localparam logic [SRC_W-1:0] SRC_SEAT2 = 3'd2;
    localparam logic [SRC_W-1:0] SRC_SEAT3 = 3'd3;
    localparam logic [SRC_W-1:0] SRC_VIP   = 3'd4;

    typedef struct packed {
        logic [SRC_W-1:0]  source;
        logic [FARE_W-1:0] fare;
    } fare_rec_t;

endpackage

// File: rtl/fare_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports: clock/reset_n (async active-low); push/wr_data write side;
// pop read side; rd_data shows the head combinationally from storage;
// count/full/empty status. A push while full is accepted only together
// with a pop in the same cycle.
module fare_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 17
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rd_data = mem[rd_ptr];

    // Storage needs no reset; the head is qualified by empty downstream.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/fare_settlement.sv
// Captures seat and VIP fares on the edge where the meter clears them,
// parks them in one pending slot per source, arbitrates them (seat0 highest,
// VIP lowest) into a FWFT record FIFO, and keeps audit counters.
// Ports: clock/reset_n (async active-low); seat_0..3, vip_enable and the
// meter cost registers as inputs; rec_valid/rec_ready/rec_source/rec_fare
// valid/ready record output; settled_total, trip_count, drop_count audit.
module fare_settlement
    import taxi_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned FARE_W = taxi_pkg::FARE_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              seat_0,
    input  logic              seat_1,
    input  logic              seat_2,
    input  logic              seat_3,
    input  logic              vip_enable,
    input  logic [FARE_W-1:0] s0cost,
    input  logic [FARE_W-1:0] s1cost,
    input  logic [FARE_W-1:0] s2cost,
    input  logic [FARE_W-1:0] s3cost,
    input  logic [FARE_W-1:0] vip_cost,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [2:0]        rec_source,
    output logic [FARE_W-1:0] rec_fare,
    output logic [16:0]       settled_total,
    output logic [7:0]        trip_count,
    output logic [7:0]        drop_count
);

    localparam int unsigned REC_W = SRC_W + FARE_W;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam int unsigned TOT_W = 17;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned DRP_W = 3;

    logic [N_SEAT-1:0] seat_in;
    logic [N_SEAT-1:0] seat_q;
    logic              vip_q;
    logic [FARE_W-1:0] src_cost [N_SRC];

    logic              vip_entry;
    logic [N_SRC-1:0]  ev;

    logic [N_SRC-1:0]  slot_valid;
    logic [FARE_W-1:0] slot_fare [N_SRC];

    logic [N_SRC-1:0]  grant;
    logic [N_SRC-1:0]  grant_eff;
    logic              any_pending;
    logic [SRC_W-1:0]  push_src;
    logic [FARE_W-1:0] push_fare;
    logic              push;
    logic              pop;

    logic [N_SRC-1:0]  drop_vec;
    logic [DRP_W-1:0]  n_drop;
    logic [CNT_W:0]    drop_sum;

    logic [REC_W-1:0]  head;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    assign seat_in     = {seat_3, seat_2, seat_1, seat_0};
    assign src_cost[0] = s0cost;
    assign src_cost[1] = s1cost;
    assign src_cost[2] = s2cost;
    assign src_cost[3] = s3cost;
    assign src_cost[4] = vip_cost;

    // Close detection on sampled inputs; VIP entry clears every open seat.
    always_comb begin
        ev        = '0;
        vip_entry = ~vip_q & vip_enable;
        for (int i = 0; i < int'(N_SEAT); i++) begin
            ev[i] = seat_q[i] & ((~seat_in[i] & ~vip_q) | vip_entry)
                    & (src_cost[i] != '0);
        end
        ev[N_SEAT] = vip_q & ~vip_enable & (vip_cost != '0);
    end

    // Fixed-priority pick of the lowest-index pending slot.
    always_comb begin
        grant       = '0;
        any_pending = 1'b0;
        push_src    = '0;
        push_fare   = '0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            if (!any_pending && slot_valid[i]) begin
                grant[i]    = 1'b1;
                any_pending = 1'b1;
                push_src    = SRC_W'(i);
                push_fare   = slot_fare[i];
            end
        end
    end

    assign pop       = ~fifo_empty & rec_ready;
    assign push      = any_pending & (~fifo_full | pop);
    assign grant_eff = push ? grant : '0;

    // A slot being pushed this edge is free to accept a new event.
    always_comb begin
        n_drop = '0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            drop_vec[i] = ev[i] & slot_valid[i] & ~grant_eff[i];
            n_drop      = n_drop + DRP_W'(drop_vec[i]);
        end
        drop_sum = {1'b0, drop_count} + (CNT_W + 1)'(n_drop);
    end

    // Input history and pending slots.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            seat_q     <= '0;
            vip_q      <= 1'b0;
            slot_valid <= '0;
            for (int i = 0; i < int'(N_SRC); i++) begin
                slot_fare[i] <= '0;
            end
        end else begin
            seat_q <= seat_in;
            vip_q  <= vip_enable;
            for (int i = 0; i < int'(N_SRC); i++) begin
                if (ev[i] && !drop_vec[i]) begin
                    slot_valid[i] <= 1'b1;
                    slot_fare[i]  <= src_cost[i];
                end else if (grant_eff[i]) begin
                    slot_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Audit counters; drops saturate, totals and trips wrap.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            settled_total <= '0;
            trip_count    <= '0;
            drop_count    <= '0;
        end else begin
            if (push) begin
                settled_total <= settled_total + TOT_W'(push_fare);
                trip_count    <= trip_count + CNT_W'(1);
            end
            drop_count <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        end
    end

    fare_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .wr_data ({push_src, push_fare}),
        .pop     (pop),
        .rd_data (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Storage is not reset, so the head is forced to zero while empty.
    assign rec_valid  = ~fifo_empty;
    assign rec_source = fifo_empty ? '0 : head[REC_W-1 -: SRC_W];
    assign rec_fare   = fifo_empty ? '0 : head[FARE_W-1:0];

    // Status flags must agree with the occupancy count.
    status_consistent: assert property (@(posedge clock) disable iff (!reset_n)
        (fifo_full == (fifo_count == CW'(DEPTH))) &&
        (fifo_empty == (fifo_count == '0)));

endmodule

// File: tb/tb_fare_settlement.sv
// Scoreboard bench for fare_settlement: expected records are queued when a
// close is driven and compared whenever the DUT presents a head record.
module tb_fare_settlement;

    logic        clock;
    logic        reset_n;
    logic [3:0]  seat;
    logic        vip_enable;
    logic [13:0] scost [4];
    logic [13:0] vip_cost;
    logic        rec_valid;
    logic        rec_ready;
    logic [2:0]  rec_source;
    logic [13:0] rec_fare;
    logic [16:0] settled_total;
    logic [7:0]  trip_count;
    logic [7:0]  drop_count;

    logic [16:0] sb [$];
    logic [16:0] exp_total;
    int unsigned exp_trips;
    int unsigned exp_drops;
    int unsigned n_checks;
    int unsigned n_errors;
    int unsigned trips_before;

    fare_settlement #(.DEPTH(8), .FARE_W(14)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .seat_0        (seat[0]),
        .seat_1        (seat[1]),
        .seat_2        (seat[2]),
        .seat_3        (seat[3]),
        .vip_enable    (vip_enable),
        .s0cost        (scost[0]),
        .s1cost        (scost[1]),
        .s2cost        (scost[2]),
        .s3cost        (scost[3]),
        .vip_cost      (vip_cost),
        .rec_valid     (rec_valid),
        .rec_ready     (rec_ready),
        .rec_source    (rec_source),
        .rec_fare      (rec_fare),
        .settled_total (settled_total),
        .trip_count    (trip_count),
        .drop_count    (drop_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_rec(input logic [2:0] src, input logic [13:0] fare);
        sb.push_back({src, fare});
        exp_total = exp_total + 17'(fare);
        exp_trips++;
    endtask

    // Occupy a seat with a fare for one cycle, then release it; meter then zeroes.
    task automatic close_seat(input int idx, input logic [13:0] fare);
        seat[idx]  = 1'b1;
        scost[idx] = fare;
        tick();
        seat[idx] = 1'b0;
        tick();
        scost[idx] = '0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || rec_valid) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) check({tag, "_timeout"}, 32'(sb.size()), 0);
        check({tag, "_total"}, 32'(settled_total), 32'(exp_total));
        check({tag, "_trips"}, 32'(trip_count), 32'(exp_trips & 8'hff));
        check({tag, "_drops"}, 32'(drop_count), 32'(exp_drops));
    endtask

    // Scoreboard monitor: head must match the oldest expected record.
    always @(negedge clock) begin
        if (reset_n && rec_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_rec", 1, 0);
            end else begin
                check("rec_source", 32'(rec_source), 32'(sb[0][16:14]));
                check("rec_fare", 32'(rec_fare), 32'(sb[0][13:0]));
                if (rec_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        exp_total  = '0;
        exp_trips  = 0;
        exp_drops  = 0;
        reset_n    = 1'b0;
        seat       = '0;
        vip_enable = 1'b0;
        vip_cost   = '0;
        rec_ready  = 1'b1;
        for (int i = 0; i < 4; i++) scost[i] = '0;

        #1;
        check("rst_valid", 32'(rec_valid), 0);
        check("rst_source", 32'(rec_source), 0);
        check("rst_fare", 32'(rec_fare), 0);
        check("rst_total", 32'(settled_total), 0);
        check("rst_trips", 32'(trip_count), 0);
        check("rst_drops", 32'(drop_count), 0);
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // Seat0 ramps to 42 then closes; record appears after the second edge.
        seat[0]  = 1'b1;
        scost[0] = 14'd10;
        for (int c = 18; c <= 42; c += 8) begin
            tick();
            scost[0] = 14'(c);
        end
        tick();
        seat[0] = 1'b0;
        expect_rec(3'd0, 14'd42);
        tick();
        scost[0] = '0;
        check("t1_valid_edge_k", 32'(rec_valid), 0);
        tick();
        check("t1_valid_edge_k1", 32'(rec_valid), 1);
        check("t1_total", 32'(settled_total), 42);
        check("t1_trips", 32'(trip_count), 1);
        wait_drain("t1", 20);

        // Seats 1 and 3 close together: two records on consecutive cycles.
        seat[1]  = 1'b1; scost[1] = 14'd30;
        seat[3]  = 1'b1; scost[3] = 14'd55;
        tick();
        seat[1] = 1'b0;
        seat[3] = 1'b0;
        expect_rec(3'd1, 14'd30);
        expect_rec(3'd3, 14'd55);
        tick();
        scost[1] = '0;
        scost[3] = '0;
        tick();
        check("t2_first_src", 32'(rec_source), 1);
        tick();
        check("t2_second_src", 32'(rec_source), 3);
        check("t2_second_valid", 32'(rec_valid), 1);
        wait_drain("t2", 20);

        // VIP entry settles open seats; seat drops during VIP are not closes.
        seat[0] = 1'b1; scost[0] = 14'd20;
        seat[2] = 1'b1; scost[2] = 14'd16;
        tick();
        vip_enable = 1'b1;
        expect_rec(3'd0, 14'd20);
        expect_rec(3'd2, 14'd16);
        tick();
        scost[0] = '0;
        scost[2] = '0;
        vip_cost = 14'd40;
        tick();
        scost[0] = 14'd5;
        seat[0]  = 1'b0;
        tick();
        scost[0] = '0;
        vip_cost = 14'd71;
        tick();
        vip_enable = 1'b0;
        expect_rec(3'd4, 14'd71);
        tick();
        vip_cost = '0;
        tick();
        seat[2] = 1'b0;
        tick();
        wait_drain("t3", 30);

        // Back-pressure: fill the FIFO, park one, drop one, then drain.
        rec_ready    = 1'b0;
        trips_before = exp_trips;
        for (int j = 0; j < 8; j++) begin
            expect_rec(3'(j % 4), 14'(100 + j));
            close_seat(j % 4, 14'(100 + j));
        end
        repeat (2) tick();
        expect_rec(3'd2, 14'd200);
        close_seat(2, 14'd200);
        repeat (2) tick();
        check("t4_full_valid", 32'(rec_valid), 1);
        check("t4_full_trips", 32'(trip_count), 32'((trips_before + 8) & 8'hff));
        close_seat(2, 14'd201);
        exp_drops++;
        tick();
        check("t4_drop", 32'(drop_count), 1);
        check("t4_held_src", 32'(rec_source), 0);
        check("t4_held_fare", 32'(rec_fare), 100);
        rec_ready = 1'b1;
        wait_drain("t4", 40);

        // Zero fare close is ignored.
        seat[0]  = 1'b1;
        scost[0] = '0;
        tick();
        seat[0] = 1'b0;
        repeat (4) tick();
        check("t5_valid", 32'(rec_valid), 0);
        check("t5_trips", 32'(trip_count), 32'(exp_trips & 8'hff));
        check("t5_total", 32'(settled_total), 32'(exp_total));

        // Reset in the middle of draining three queued records.
        rec_ready = 1'b0;
        expect_rec(3'd1, 14'd7);
        close_seat(1, 14'd7);
        expect_rec(3'd2, 14'd8);
        close_seat(2, 14'd8);
        expect_rec(3'd3, 14'd9);
        close_seat(3, 14'd9);
        repeat (2) tick();
        check("t6_queued_valid", 32'(rec_valid), 1);
        rec_ready = 1'b1;
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        sb.delete();
        exp_total = '0;
        exp_trips = 0;
        exp_drops = 0;
        check("t6_rst_valid", 32'(rec_valid), 0);
        check("t6_rst_source", 32'(rec_source), 0);
        check("t6_rst_fare", 32'(rec_fare), 0);
        check("t6_rst_total", 32'(settled_total), 0);
        check("t6_rst_trips", 32'(trip_count), 0);
        check("t6_rst_drops", 32'(drop_count), 0);
        tick();
        reset_n = 1'b1;
        tick();
        expect_rec(3'd0, 14'd12);
        close_seat(0, 14'd12);
        wait_drain("t6", 20);
        check("t6_trip_one", 32'(trip_count), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
